// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if: valid/ready word handshake into the serial frame transmitter
interface serial_frame_tx_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: start / LSB-first data / optional even parity / stop serializer with programmable bit period
module serial_frame_tx #(
    parameter int DATA_W    = 8,
    parameter int DIV_W     = 16,
    parameter int PARITY_EN = 1
) (
    input  logic             mclk,
    input  logic             mreset_n,
    input  logic [DIV_W-1:0] baud_div,
    serial_frame_tx_if.slave bus,
    output logic             tx_line,
    output logic             tx_busy,
    output logic             frame_done
);
    localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t            state, state_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic [DIV_W-1:0]  div_lat, div_n, cnt, cnt_n;
    logic [IW-1:0]     idx, idx_n;
    logic              par, par_n, line_n, done_n, wrap, last;
    assign wrap         = cnt == div_lat;
    assign last         = idx == IW'(DATA_W - 1);
    assign bus.tx_ready = state == IDLE;
    assign tx_busy      = state != IDLE;
    always_comb begin
        state_n = state;
        shift_n = shift;
        div_n   = div_lat;
        idx_n   = idx;
        par_n   = par;
        cnt_n   = wrap ? '0 : cnt + DIV_W'(1);
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (bus.tx_valid) begin
                    state_n = START;
                    shift_n = bus.tx_data;
                    div_n   = baud_div;
                    idx_n   = '0;
                    par_n   = ^bus.tx_data;
                end
            end
            START: if (wrap) state_n = DATA;
            DATA: if (wrap) begin
                shift_n = shift >> 1;
                idx_n   = last ? '0 : idx + IW'(1);
                if (last) state_n = PARITY_EN != 0 ? PARITY : STOP;
            end
            PARITY: if (wrap) state_n = STOP;
            default: if (wrap) state_n = IDLE;
        endcase
        // line and done are registered from next-state values so they align with the state they describe
        line_n = state_n == START  ? 1'b0 :
                 state_n == DATA   ? shift_n[0] :
                 state_n == PARITY ? par_n : 1'b1;
        done_n = state_n == STOP && cnt_n == div_n;
    end
    always_ff @(posedge mclk or negedge mreset_n) begin
        if (!mreset_n) begin
            state      <= IDLE;
            shift      <= '0;
            div_lat    <= '0;
            cnt        <= '0;
            idx        <= '0;
            par        <= 1'b0;
            tx_line    <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            div_lat    <= div_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            par        <= par_n;
            tx_line    <= line_n;
            frame_done <= done_n;
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: randomized frame-level checks of serial_frame_tx against a bit-list model
module tb_serial_frame_tx;
    logic mclk = 1'b0, mreset_n = 1'b0, sel = 1'b0;
    logic [15:0] bd0 = '0, bd1 = '0;
    logic line0, line1, busy0, busy1, done0, done1;
    logic line, busy, done, rdy;
    int checks = 0, errors = 0;
    serial_frame_tx_if #(.DATA_W(8)) if0 ();
    serial_frame_tx_if #(.DATA_W(8)) if1 ();
    serial_frame_tx #(.DATA_W(8), .DIV_W(16), .PARITY_EN(1)) dut0 (
        .mclk(mclk), .mreset_n(mreset_n), .baud_div(bd0), .bus(if0),
        .tx_line(line0), .tx_busy(busy0), .frame_done(done0));
    serial_frame_tx #(.DATA_W(8), .DIV_W(16), .PARITY_EN(0)) dut1 (
        .mclk(mclk), .mreset_n(mreset_n), .baud_div(bd1), .bus(if1),
        .tx_line(line1), .tx_busy(busy1), .frame_done(done1));
    always #5 mclk = ~mclk;
    assign line = sel ? line1 : line0;
    assign busy = sel ? busy1 : busy0;
    assign done = sel ? done1 : done0;
    assign rdy  = sel ? if1.tx_ready : if0.tx_ready;

    // frame as an ordered bit list: start, data LSB first, optional parity, stop
    function automatic logic frame_bit(input logic [7:0] d, input int pe, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (pe != 0 && b == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic drive(input logic s, input logic v, input logic [7:0] d, input int div);
        if (s) begin
            if1.tx_valid = v; if1.tx_data = d; bd1 = 16'(div);
        end else begin
            if0.tx_valid = v; if0.tx_data = d; bd0 = 16'(div);
        end
    endtask

    // mode 0: valid low while busy; 1: random valid pulses while busy; 2: valid held with nd for back-to-back
    task automatic send(input logic s, input logic [7:0] d, input int div, input int mode, input logic [7:0] nd);
        int pe, len;
        logic exp_l;
        sel = s;
        pe  = s ? 0 : 1;
        len = (div + 1) * (8 + 2 + pe);
        @(negedge mclk);
        checks++;
        if (rdy !== 1'b1 || line !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_before_frame ready=%b line=%b busy=%b done=%b want 1 1 0 0", rdy, line, busy, done);
        end
        drive(s, 1'b1, d, div);
        for (int k = 1; k <= len; k++) begin
            @(negedge mclk);
            if (mode == 2) drive(s, 1'b1, nd, $urandom_range(0, 15));
            else drive(s, (mode == 1 && k < len) ? 1'($urandom % 2) : 1'b0, 8'($urandom), $urandom_range(0, 15));
            exp_l = frame_bit(d, pe, (k - 1) / (div + 1));
            checks++;
            if (line !== exp_l || done !== (k == len) || busy !== 1'b1 || rdy !== 1'b0) begin
                errors++;
                $display("FAIL frame d=%h div=%0d cycle=%0d line=%b done=%b busy=%b ready=%b want %b %b 1 0",
                         d, div, k, line, done, busy, rdy, exp_l, k == len);
            end
        end
    endtask

    task automatic idle_check(input int n);
        drive(sel, 1'b0, 8'($urandom), $urandom_range(0, 15));
        for (int k = 0; k < n; k++) begin
            @(negedge mclk);
            checks++;
            if (rdy !== 1'b1 || line !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL idle ready=%b line=%b busy=%b done=%b want 1 1 0 0", rdy, line, busy, done);
            end
        end
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            @(negedge mclk);
            checks++;
            if ({line0, line1, if0.tx_ready, if1.tx_ready, busy0, busy1, done0, done1} !== 8'b11110000) begin
                errors++;
                $display("FAIL reset_state got %b want 11110000",
                         {line0, line1, if0.tx_ready, if1.tx_ready, busy0, busy1, done0, done1});
            end
        end
        mreset_n = 1'b1;
        idle_check(2);
    endtask

    task automatic test_a5;
        send(1'b0, 8'hA5, 3, 0, 8'h00);
        idle_check(2);
    endtask

    task automatic test_back_to_back;
        send(1'b0, 8'hFF, 0, 2, 8'h01);
        send(1'b0, 8'h01, 0, 0, 8'h00);
        idle_check(2);
    endtask

    task automatic test_no_parity;
        send(1'b1, 8'h80, 1, 0, 8'h00);
        idle_check(2);
    endtask

    task automatic test_in_flight;
        send(1'b0, 8'h3C, 2, 1, 8'h00);
        idle_check(4);
    endtask

    task automatic test_reset_mid;
        sel = 1'b0;
        @(negedge mclk);
        drive(1'b0, 1'b1, 8'h00, 5);
        for (int k = 1; k <= 10; k++) begin
            @(negedge mclk);
            drive(1'b0, 1'b0, 8'($urandom), $urandom_range(0, 15));
        end
        checks++;
        if (line0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_data line=%b busy=%b want 0 1", line0, busy0);
        end
        #1 mreset_n = 1'b0;
        #1;
        checks++;
        if (line0 !== 1'b1 || busy0 !== 1'b0 || if0.tx_ready !== 1'b1 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset line=%b busy=%b ready=%b done=%b want 1 0 1 0", line0, busy0, if0.tx_ready, done0);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge mclk);
            checks++;
            if (line0 !== 1'b1 || done0 !== 1'b0) begin
                errors++;
                $display("FAIL in_reset line=%b done=%b want 1 0", line0, done0);
            end
        end
        mreset_n = 1'b1;
        idle_check(3);
        send(1'b0, 8'h55, $urandom_range(0, 5), 0, 8'h00);
        idle_check(2);
    endtask

    task automatic test_random;
        logic [7:0] d, nd;
        logic s, c;
        int m;
        c = 1'b0;
        s = 1'b0;
        nd = '0;
        for (int i = 0; i < 24; i++) begin
            if (!c) begin
                s = 1'($urandom % 2);
                d = 8'($urandom);
            end else d = nd;
            m  = (i == 23) ? int'($urandom % 2) : int'($urandom % 3);
            nd = 8'($urandom);
            send(s, d, $urandom_range(0, 4), m, nd);
            c = m == 2;
        end
        idle_check(3);
    endtask

    initial begin
        drive(1'b0, 1'b0, 8'h00, 0);
        drive(1'b1, 1'b0, 8'h00, 0);
        test_reset;
        test_a5;
        test_back_to_back;
        test_no_parity;
        test_in_flight;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Serializing transmitter for the single-wire frame protocol whose receiver is the mclk-domain level-tracking state machine. It accepts parallel words through a valid/ready handshake and drives one line with start bit, data bits LSB first, optional even parity, and stop bit. A programmable divider sets the bit period. It sits on the cell_lib datapath edge, next to the receive-side FSM, on the same clock.

Parameters:
DATA_W, 8, data bits per frame (1..16)
DIV_W, 16, width of bit-period divider
PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = no parity bit

Ports:
mclk  input  1  system clock, rising edge
mreset_n  input  1  reset, asynchronous, active-low
baud_div  input  DIV_W  bit period minus one, in mclk cycles
tx_data  input  DATA_W  word to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a word this cycle
tx_line  output  1  serial output, idle high
tx_busy  output  1  frame in progress (any state except IDLE)
frame_done  output  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Interface: one clock, mclk. Reset mreset_n is asynchronous, active-low.
- Reset values: tx_line=1, tx_ready=1, tx_busy=0, frame_done=0, state=IDLE, all counters 0.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_ready=1, tx_line=1.
  - Handshake completes on tx_valid && tx_ready at a rising edge.
  - At that edge, tx_data goes into the shift register, baud_div goes into div_lat, and the state becomes START.
  - tx_data/baud_div changes after acceptance do not affect the frame in flight.
- tx_ready=0 in every state except IDLE.
- Bit timing:
  - bit_cnt counts 0..div_lat, then wraps to 0 and advances to the next bit.
  - Each bit holds tx_line for exactly div_lat+1 cycles.
  - div_lat=0 gives one cycle per bit.
- START: tx_line=0 for one bit period, then DATA.
- DATA:
  - tx_line = shift[0]; shift right at each bit boundary.
  - A data index counts 0..DATA_W-1.
  - After bit DATA_W-1: go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx_line = XOR of the latched word (even parity: total ones in data+parity is even), for one bit period.
- STOP: tx_line=1 for one bit period.
  - frame_done=1 on the final cycle of the stop bit only.
  - Next state is IDLE.
- Latency and frame length:
  - The start bit appears on tx_line in the cycle after the accept edge.
  - Frame length = (div_lat+1)*(DATA_W+2+PARITY_EN) cycles.
- Back-to-back: after frame_done, one IDLE cycle with tx_ready=1 follows. If tx_valid is high then, the next start bit begins the following cycle. Line stays high between frames.
- tx_valid while busy is ignored and not queued; the source must hold tx_valid until tx_ready.
- Reset mid-frame: tx_line goes to 1 immediately, without waiting for mclk. The frame is discarded, there is no frame_done, and tx_ready=1 after reset release.
- Outputs tx_line and frame_done are registered, so they are glitch-free.

Test Plan:
- DATA_W=8, PARITY_EN=1, baud_div=3, send 8'hA5 → tx_line:
  - 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each;
  - parity 0 for 4 cycles, stop 1 for 4 cycles;
  - 44 cycles total; frame_done pulses in cycle 44; tx_ready back high in cycle 45.
- baud_div=0, send 8'hFF then 8'h01 with tx_valid held high → 11-cycle frames:
  - parity 0 for 8'hFF and 1 for 8'h01;
  - exactly one idle-high cycle between the two frames;
  - two frame_done pulses.
- PARITY_EN=0, baud_div=1, send 8'h80 → 20-cycle frame; bit 7 (last data bit) high; no parity slot.
- Accept 8'h3C, then change tx_data to 8'hFF and baud_div to 7 during the frame → serialized bits still 8'h3C at the original period; tx_valid pulses while busy are not sent.
- Assert mreset_n=0 mid-DATA with baud_div=5 → tx_line=1 asynchronously; no frame_done. After release, a new 8'h55 frame transmits correctly from a start bit.
